// File: rtl/miller_rx_pkg.sv
// Shared definitions for the modified-Miller receive frame controller:
// controller state encoding, timing constants and small helpers.
package miller_rx_pkg;

  // Clocks per 106 kb/s ETU at fc/4.
  localparam int CLK_PER_ETU = 32;
  // ETUs without a decoded bit, while receiving, before the frame is abandoned.
  localparam int TIMEOUT_ETU = 4;
  // Largest standard frame, in bytes.
  localparam int MAX_BYTES   = 64;

  // Controller states, IDLE=0 .. ERR=4.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_RX   = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  // Width of the within-ETU clock counter.
  function automatic int etu_cnt_width(input int clk_per_etu);
    return (clk_per_etu > 1) ? $clog2(clk_per_etu) : 1;
  endfunction

  // A received character is 8 data bits plus odd parity, so the nine bits
  // must hold an odd number of ones.
  function automatic logic parity_bad(input logic [8:0] char_bits);
    return ~(^char_bits);
  endfunction

endpackage

// File: rtl/miller_rx_frame_ctrl_etu_timer.sv
// Bit-gap watchdog: counts clocks since the last restart, split into a
// within-ETU clock counter and an ETU counter. tc rises on the last clock of
// the TIMEOUT_ETU-th ETU and stays there until the next restart.
module etu_timer #(
  parameter int CLK_PER_ETU = miller_rx_pkg::CLK_PER_ETU,
  parameter int TIMEOUT_ETU = miller_rx_pkg::TIMEOUT_ETU
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tc
);

  localparam int CW = miller_rx_pkg::etu_cnt_width(CLK_PER_ETU);
  localparam int EW = (TIMEOUT_ETU > 1) ? $clog2(TIMEOUT_ETU) : 1;

  localparam logic [CW-1:0] CLK_LAST = CW'(CLK_PER_ETU - 1);
  localparam logic [EW-1:0] ETU_LAST = EW'(TIMEOUT_ETU - 1);

  logic [CW-1:0] clk_cnt;
  logic [EW-1:0] etu_cnt;

  assign tc = (clk_cnt == CLK_LAST) && (etu_cnt == ETU_LAST);

  // Gap counter: cleared by restart, saturates at terminal count.
  // NOTE: registered state is written with non-blocking assignments only, so
  // every flop samples its inputs from before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_cnt <= '0;
      etu_cnt <= '0;
    end else if (restart) begin
      clk_cnt <= '0;
      etu_cnt <= '0;
    end else if (!tc) begin
      if (clk_cnt == CLK_LAST) begin
        clk_cnt <= '0;
        etu_cnt <= etu_cnt + 1'b1;
      end else begin
        clk_cnt <= clk_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/miller_rx_frame_ctrl.sv
// Sequencer for the modified-Miller receive chain. Arms the SoF detector,
// gates the Miller decoder, assembles decoded bits into bytes (8 data bits
// LSB first + odd parity), classifies each frame as short (7 bits),
// standard (N x 9 bits) or erroneous, and re-arms the chain afterwards.
module miller_rx_frame_ctrl #(
  parameter int CLK_PER_ETU = miller_rx_pkg::CLK_PER_ETU,
  parameter int TIMEOUT_ETU = miller_rx_pkg::TIMEOUT_ETU,
  parameter int MAX_BYTES   = miller_rx_pkg::MAX_BYTES,
  localparam int BYTE_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_rx_en,
  input  logic              in_sof,
  input  logic              in_bit_valid,
  input  logic              in_bit,
  input  logic              in_eof,
  output logic              out_sof_arm,
  output logic              out_dec_en,
  output logic              out_rearm,
  output logic [7:0]        out_byte,
  output logic              out_byte_valid,
  output logic              out_parity_err,
  output logic              out_short_frame,
  output logic              out_frame_done,
  output logic              out_frame_err,
  output logic [BYTE_W-1:0] out_byte_cnt
);

  import miller_rx_pkg::*;

  localparam logic [BYTE_W-1:0] BYTE_MAX = BYTE_W'(MAX_BYTES);

  state_t state, state_d;

  // Bit assembly: bits enter at [8] and walk down, so after nine bits the
  // first (LSB) data bit sits in [0] and the parity bit in [8].
  logic [8:0]        shreg, shreg_nxt;
  logic [3:0]        bit_cnt, bit_cnt_nxt;
  logic [BYTE_W-1:0] byte_cnt, byte_cnt_nxt;

  logic ninth_bit;
  logic overflow;
  logic eof_done;
  logic eof_short;
  logic timer_restart;
  logic timer_tc;
  logic timeout;
  logic rx_entry;

  // Next values of the registered outputs.
  logic       sof_arm_d;
  logic       dec_en_d;
  logic       rearm_d;
  logic [7:0] byte_d;
  logic       byte_valid_d;
  logic       parity_err_d;
  logic       short_d;
  logic       frame_done_d;
  logic       frame_err_d;

  // The gap timer runs only in RX and restarts on entry and on every bit.
  assign timer_restart = (state != ST_RX) || in_bit_valid;
  assign timeout       = timer_tc && !in_bit_valid;
  assign rx_entry      = (state == ST_ARM) && (state_d == ST_RX);

  etu_timer #(
    .CLK_PER_ETU (CLK_PER_ETU),
    .TIMEOUT_ETU (TIMEOUT_ETU)
  ) u_etu_timer (
    .clk     (in_clk),
    .rst     (in_rst),
    .restart (timer_restart),
    .tc      (timer_tc)
  );

  // Absorb a same-cycle decoded bit so that in_eof is judged on the counts
  // that include it.
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    shreg_nxt    = shreg;
    bit_cnt_nxt  = bit_cnt;
    byte_cnt_nxt = byte_cnt;
    ninth_bit    = 1'b0;
    if ((state == ST_RX) && in_bit_valid) begin
      shreg_nxt = {in_bit, shreg[8:1]};
      if (bit_cnt == 4'd8) begin
        ninth_bit   = 1'b1;
        bit_cnt_nxt = '0;
        if (byte_cnt != BYTE_MAX) begin
          byte_cnt_nxt = byte_cnt + 1'b1;
        end
      end else begin
        bit_cnt_nxt = bit_cnt + 4'd1;
      end
    end
  end

  assign overflow  = ninth_bit && (byte_cnt == BYTE_MAX);
  assign eof_done  = (bit_cnt_nxt == 4'd0) && (byte_cnt_nxt != '0);
  assign eof_short = (bit_cnt_nxt == 4'd7) && (byte_cnt_nxt == '0);

  // State register.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic; dropping in_rx_en beats every frame event.
  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE: begin
        if (in_rx_en) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (!in_rx_en)   state_d = ST_IDLE;
        else if (in_sof) state_d = ST_RX;
      end
      ST_RX: begin
        if (!in_rx_en)     state_d = ST_IDLE;
        else if (overflow) state_d = ST_ERR;
        else if (in_eof)   state_d = (eof_done || eof_short) ? ST_DONE : ST_ERR;
        else if (timeout)  state_d = ST_ERR;
      end
      ST_DONE, ST_ERR: begin
        state_d = in_rx_en ? ST_ARM : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode: levels and strobes follow the state being entered, so the
  // registered copies line up with that state.
  always_comb begin
    sof_arm_d    = (state_d == ST_ARM);
    dec_en_d     = (state_d == ST_RX);
    frame_done_d = (state_d == ST_DONE);
    frame_err_d  = (state_d == ST_ERR);
    rearm_d      = (state_d == ST_DONE) || (state_d == ST_ERR) ||
                   ((state_d == ST_IDLE) && ((state == ST_ARM) || (state == ST_RX)));
    byte_d       = out_byte;
    byte_valid_d = 1'b0;
    parity_err_d = 1'b0;
    short_d      = 1'b0;
    if ((state == ST_RX) && in_rx_en) begin
      if (ninth_bit && !overflow) begin
        byte_d       = shreg_nxt[7:0];
        byte_valid_d = 1'b1;
        parity_err_d = parity_bad(shreg_nxt);
      end else if (in_eof && eof_short) begin
        // Seven bits entered at [8] and now occupy [8:2], first bit at [2].
        byte_d       = {1'b0, shreg_nxt[8:2]};
        byte_valid_d = 1'b1;
        short_d      = 1'b1;
      end
    end
  end

  // Bit/byte assembly registers; counters clear on entry to RX and the byte
  // count then holds through DONE/ERR until the next frame.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
    end else if (rx_entry) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
    end else begin
      shreg    <= shreg_nxt;
      bit_cnt  <= bit_cnt_nxt;
      byte_cnt <= byte_cnt_nxt;
    end
  end

  assign out_byte_cnt = byte_cnt;

  // Output registers.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      out_sof_arm     <= 1'b0;
      out_dec_en      <= 1'b0;
      out_rearm       <= 1'b0;
      out_byte        <= '0;
      out_byte_valid  <= 1'b0;
      out_parity_err  <= 1'b0;
      out_short_frame <= 1'b0;
      out_frame_done  <= 1'b0;
      out_frame_err   <= 1'b0;
    end else begin
      out_sof_arm     <= sof_arm_d;
      out_dec_en      <= dec_en_d;
      out_rearm       <= rearm_d;
      out_byte        <= byte_d;
      out_byte_valid  <= byte_valid_d;
      out_parity_err  <= parity_err_d;
      out_short_frame <= short_d;
      out_frame_done  <= frame_done_d;
      out_frame_err   <= frame_err_d;
    end
  end

endmodule
